// File: rtl/zprize_mul_384_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : zprize_mul_384_feeder
//  Description : Credit-based issue/collect wrapper around a fixed-latency,
//                non-stallable 384x384 multiplier. Operand pairs and a tag
//                are accepted on a valid/ready port and registered into the
//                multiplier. Products and tags are captured into a result
//                FIFO (first-word-fall-through, registered outputs).
//                Credits reserve one FIFO slot per in-flight operation, so
//                consumer backpressure can never cause a result to be lost.
//  Ports       : clk, rstN (async, active low)
//                s_valid/s_ready/s_in0/s_in1/s_tag   operand input port
//                mul_in0/mul_in1/mul_m_i             to multiplier (registered)
//                mul_out0/mul_m_o                    from multiplier
//                m_valid/m_ready/m_prod/m_tag        result output port
//                credit                              free credits (status)
//  Revision    : 1.0 - initial release
// ============================================================================
module zprize_mul_384_feeder #(
    parameter int W       = 384,
    parameter int M       = 32,
    parameter int MUL_LAT = 6,
    parameter int DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [W-1:0]                 s_in0,
    input  logic [W-1:0]                 s_in1,
    input  logic [M-1:0]                 s_tag,
    output logic [W-1:0]                 mul_in0,
    output logic [W-1:0]                 mul_in1,
    output logic [M-1:0]                 mul_m_i,
    input  logic [2*W-1:0]               mul_out0,
    input  logic [M-1:0]                 mul_m_o,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [2*W-1:0]               m_prod,
    output logic [M-1:0]                 m_tag,
    output logic [$clog2(DEPTH+1)-1:0]   credit
);

    localparam int C_CRED_W = $clog2(DEPTH + 1);
    localparam int C_AW     = $clog2(DEPTH);
    localparam int C_DW     = M + 2 * W;

    localparam logic [C_CRED_W-1:0] C_DEPTH = C_CRED_W'(DEPTH);
    localparam logic [C_AW-1:0]     C_LAST  = C_AW'(DEPTH - 1);

    // Parameter legality: the FIFO must cover every op that can be in flight.
    if (DEPTH < MUL_LAT + 2) begin : g_bad_depth
        $error("zprize_mul_384_feeder: DEPTH must be >= MUL_LAT+2");
    end
    if (MUL_LAT < 1) begin : g_bad_lat
        $error("zprize_mul_384_feeder: MUL_LAT must be >= 1");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [C_CRED_W-1:0] r_credit;
    logic                r_run;        // high from the first clk after reset
    logic [MUL_LAT:0]    r_vld_sr;     // tracks which multiplier slots hold a real op
    logic [W-1:0]        r_mul_in0;
    logic [W-1:0]        r_mul_in1;
    logic [M-1:0]        r_mul_m_i;
    logic [C_DW-1:0]     r_mem [DEPTH];
    logic [C_AW:0]       r_wr_ptr;     // {wrap, index}
    logic [C_AW:0]       r_rd_ptr;
    logic                r_m_valid;
    logic [C_DW-1:0]     r_head;       // registered FIFO head {tag, product}

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic            w_issue;
    logic            w_pop;
    logic            w_wr;
    logic            w_full;
    logic [C_AW:0]   w_wr_ptr_nxt;
    logic [C_AW:0]   w_rd_ptr_nxt;
    logic            w_empty_nxt;
    logic [C_DW-1:0] w_wr_data;
    logic [C_DW-1:0] w_head_nxt;

    // Pointer increment with wrap at DEPTH-1; the top bit toggles on wrap so
    // that equal indices can be told apart as empty (same wrap) or full.
    function automatic logic [C_AW:0] ptr_inc(input logic [C_AW:0] p);
        if (p[C_AW-1:0] == C_LAST)
            return {~p[C_AW], {C_AW{1'b0}}};
        else
            return {p[C_AW], p[C_AW-1:0] + 1'b1};
    endfunction

    assign s_ready   = r_run && (r_credit != '0);
    assign w_issue   = s_valid && s_ready;
    assign w_pop     = r_m_valid && m_ready;
    assign w_wr      = r_vld_sr[MUL_LAT];
    assign w_wr_data = {mul_m_o, mul_out0};
    assign w_full    = (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]) &&
                       (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]);

    always_comb begin
        w_wr_ptr_nxt = w_wr  ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_rd_ptr_nxt = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        // If the next head slot is the one being written this edge, bypass
        // the write data; this covers write+pop at occupancy 1 and the
        // write into an empty FIFO.
        if (w_rd_ptr_nxt == r_wr_ptr)
            w_head_nxt = w_wr_data;
        else
            w_head_nxt = r_mem[w_rd_ptr_nxt[C_AW-1:0]];
    end

    // ------------------------------------------------------------------------
    // Issue side and credit
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_run     <= 1'b0;
            r_credit  <= C_DEPTH;
            r_vld_sr  <= '0;
            r_mul_in0 <= '0;
            r_mul_in1 <= '0;
            r_mul_m_i <= '0;
        end else begin
            r_run    <= 1'b1;
            r_vld_sr <= {r_vld_sr[MUL_LAT-1:0], w_issue};
            if (w_issue) begin
                r_mul_in0 <= s_in0;
                r_mul_in1 <= s_in1;
                r_mul_m_i <= s_tag;
            end else begin
                r_mul_in0 <= '0;
                r_mul_in1 <= '0;
                r_mul_m_i <= '0;
            end
            if (w_issue && !w_pop)
                r_credit <= r_credit - 1'b1;
            else if (w_pop && !w_issue)
                r_credit <= r_credit + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------------
    // Storage needs no reset: occupancy is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr[C_AW-1:0]] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_head    <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_m_valid <= !w_empty_nxt;
            // Holding while valid and not popped reloads the same entry,
            // so the head stays stable under backpressure.
            if (!w_empty_nxt)
                r_head <= w_head_nxt;
        end
    end

    assign mul_in0 = r_mul_in0;
    assign mul_in1 = r_mul_in1;
    assign mul_m_i = r_mul_m_i;
    assign m_valid = r_m_valid;
    assign m_prod  = r_head[2*W-1:0];
    assign m_tag   = r_head[C_DW-1:2*W];
    assign credit  = r_credit;

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (!rstN)
        !(w_wr && w_full));
    a_credit_range : assert property (@(posedge clk) disable iff (!rstN)
        (r_credit <= C_DEPTH));
`endif

endmodule
`default_nettype wire
